lc3_ctrl_seq: RTL and testbench
===============================

// Module: lc3_ctrl_seq
// PURPOSE
//  LC-3 control sequencer for the lab6 SLC-3: a Moore FSM driving the datapath load, gate, mux and SRAM strobes.
//  Single-cycle-per-access SRAM states are replaced by a parametrised wait counter.
//  Full instruction set: ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR, LEA, PSE; other opcodes return to fetch.
//  Sits between IR/BEN/CC logic and the datapath/SRAM interface.
// PARAMETERS
//  MEM_WAIT   2   cycles Mem_OE/Mem_WE stay low per SRAM access; legal range 1..15
// PORTS
//  Clk        in   1  clock
//  Reset      in   1  synchronous, active-high; forces Halted
//  Run        in   1  start from Halted
//  Continue   in   1  resume from a pause (level; wait high then low)
//  Opcode     in   4  IR[15:12]
//  IR_5       in   1  ADD/AND imm select
//  IR_11      in   1  JSR(1)/JSRR(0) select
//  BEN        in   1  branch enable
//  LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,LD_LED  out 1 each  register loads
//  GatePC,GateMDR,GateALU,GateMARMUX  out 1 each  bus drivers (one-hot or all 0)
//  PCMUX      out  2  00 PC+1, 01 bus, 10 adder
//  DRMUX      out  1  0 IR[11:9], 1 R7
//  SR1MUX     out  1  0 IR[11:9], 1 IR[8:6]
//  SR2MUX     out  1  0 register, 1 sext imm5
//  ADDR1MUX   out  1  0 PC, 1 SR1
//  ADDR2MUX   out  2  00 zero, 01 off6, 10 off9, 11 off11
//  ALUK       out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
//  Mem_CE,Mem_UB,Mem_LB  out 1  tied 0
//  Mem_OE,Mem_WE         out 1  active-low strobes
// BEHAVIOUR
//  Reset value of every output: all LD_*/Gate*/mux/ALUK = 0; Mem_OE = Mem_WE = 1; wait counter = 0.
//  Outputs are pure functions of State; Next_state registered on posedge Clk.
//  Halted -> S18 when Run = 1; otherwise stays Halted. Run outside Halted is ignored.
//  Fetch: S18 (MAR<-PC, PC<-PC+1) -> S33 (Mem_OE=0 for MEM_WAIT cycles; LD_MDR=1 only on the last) -> S35 (IR<-MDR) -> S32.
//  S32: LD_BEN=1, then dispatch on Opcode:
//    ADD S01, AND S05, NOT S09, LEA S14, LDR S06, STR S07, JSR S04, JMP S12, BR S00, PSE PseA; others -> S18.
//  ALU ops (S01/S05/S09): SR1MUX=1, SR2MUX=IR_5, GateALU, LD_REG, LD_CC -> S18.
//  LEA S14: ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_REG, LD_CC -> S18.
//  LDR: S06 MAR<-SR1+off6 -> S25 (read, MEM_WAIT cycles) -> S27 DR<-MDR, LD_CC -> S18.
//  STR: S07 MAR<-SR1+off6 -> S23 MDR<-SR (SR1MUX=0, ALUK=11) -> S16 (Mem_WE=0 for MEM_WAIT cycles) -> S18.
//  JSR: S04 R7<-PC (DRMUX=1, GatePC, LD_REG) -> S21 PC<-PC+off11 when IR_11=1, else PC<-SR1 -> S18.
//  JMP S12: PC<-SR1 (ADDR1MUX=1, ADDR2MUX=00, PCMUX=10) -> S18.
//  BR: S00 -> S22 (PC<-PC+off9) when BEN = 1, else -> S18.
//  PSE: PseA asserts LD_LED=1 on its first cycle only; stays in PseA until Continue=1, then PseB stays until Continue=0, then -> S18.
//  Wait counter: loaded with MEM_WAIT-1 on entry to S33/S25/S16 and decremented; leaves the state when it reaches 0.
//    With MEM_WAIT=1 each memory state lasts exactly one cycle.
//  Reset mid-access deasserts Mem_OE/Mem_WE in the next cycle; no partial LD_MDR.
//  Illegal state encodings -> S18 with default outputs.
// CONFIGURATION
//  LC3_PAUSE_IR_EN defined: S35 -> PauseIR1 (wait Continue=1) -> PauseIR2 (wait Continue=0) -> S18, with no execution.
//    This is the week-1 IR inspection mode; LD_LED=0 throughout.
//  LC3_PAUSE_IR_EN undefined: S35 -> S32; PauseIR states are absent from the enum.
// STRUCTURE
//  lc3_ctrl_pkg holds:
//    state_t enum; opcode localparams (OP_ADD...OP_PSE);
//    PCMUX/ADDR2MUX/ALUK encodings as localparams.
//  Sub-module mem_wait_timer (load, dec, done) holds the MEM_WAIT counter.
//  FSM and output decode stay in lc3_ctrl_seq.
// TESTING
//  Reset; Run=1 for one cycle, MEM_WAIT=2 -> S18,S33,S33,S35,S32; Mem_OE=0 for exactly 2 cycles; LD_MDR on the 2nd only.
//  MEM_WAIT=4, STR opcode 0111 -> S07,S23, then Mem_WE=0 for 4 cycles, then S18; LD_MDR=1 only in S23.
//  BR 0000: BEN=0 -> S18 straight after S00; BEN=1 -> S22 with PCMUX=10, ADDR2MUX=10, LD_PC=1.
//  JSR: IR_11=1 -> S21 ADDR2MUX=11; IR_11=0 -> ADDR1MUX=1, ADDR2MUX=00; S04 always has DRMUX=1.
//  PSE 1101: LD_LED pulses for 1 cycle; Continue held high 5 cycles stays in PseB; falling Continue -> S18.
//  Reset asserted mid-S25 -> Halted next cycle with Mem_OE=1; repeat with and without LC3_PAUSE_IR_EN.

Source files
------------

// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the SLC-3 control sequencer: state encoding, opcodes, mux encodings, control bundle.
// LC3_PAUSE_IR_EN adds the IR inspection pause states to state_t.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S14,
    S06, S25, S27,
    S07, S23, S16,
    S04, S21, S12,
    S00, S22,
    PSE_A, PSE_B
`ifdef LC3_PAUSE_IR_EN
    , PAUSE_IR1, PAUSE_IR2
`endif
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic logic is_mem_state(state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/lc3_ctrl_seq_mem_wait_timer.sv
// SRAM access wait counter: holds a memory state for MEM_WAIT cycles (legal 1..15).
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic done,
  output logic done_next
);

  localparam logic [3:0] RELOAD = 4'(MEM_WAIT - 1);

  logic [3:0] count;

  always_ff @(posedge Clk) begin
    if (Reset)            count <= '0;
    else if (load)        count <= RELOAD;
    else if (dec && !done) count <= count - 4'd1;
  end

  assign done = (count == '0);

  // Lookahead of done, so the FSM can register LD_MDR for the final access cycle.
  always_comb begin
    if (load)              done_next = (RELOAD == '0);
    else if (dec && !done) done_next = (count == 4'd1);
    else                   done_next = done;
  end

endmodule

// File: rtl/lc3_ctrl_seq.sv
// SLC-3 Moore control sequencer with parametrised SRAM wait states.
// Define LC3_PAUSE_IR_EN to stop after each fetch for IR inspection instead of executing.
module lc3_ctrl_seq
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state, next_state;
  ctrl_t  ctrl_d, ctrl_q;
  logic   timer_load, timer_dec, timer_done, timer_done_next;

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (timer_load),
    .dec       (timer_dec),
    .done      (timer_done),
    .done_next (timer_done_next)
  );

  assign timer_load = is_mem_state(next_state) && (next_state != state);
  assign timer_dec  = is_mem_state(state) && (next_state == state);

  always_comb begin
    next_state = S18;
    case (state)
      HALTED: next_state = Run ? S18 : HALTED;
      S18:    next_state = S33;
      S33:    next_state = timer_done ? S35 : S33;
`ifdef LC3_PAUSE_IR_EN
      S35:       next_state = PAUSE_IR1;
      PAUSE_IR1: next_state = Continue ? PAUSE_IR2 : PAUSE_IR1;
      PAUSE_IR2: next_state = Continue ? PAUSE_IR2 : S18;
`else
      S35:    next_state = S32;
`endif
      S32: begin
        case (Opcode)
          OP_ADD:  next_state = S01;
          OP_AND:  next_state = S05;
          OP_NOT:  next_state = S09;
          OP_LEA:  next_state = S14;
          OP_LDR:  next_state = S06;
          OP_STR:  next_state = S07;
          OP_JSR:  next_state = S04;
          OP_JMP:  next_state = S12;
          OP_BR:   next_state = S00;
          OP_PSE:  next_state = PSE_A;
          default: next_state = S18;
        endcase
      end
      S06:    next_state = S25;
      S25:    next_state = timer_done ? S27 : S25;
      S07:    next_state = S23;
      S23:    next_state = S16;
      S16:    next_state = timer_done ? S18 : S16;
      S04:    next_state = S21;
      S00:    next_state = BEN ? S22 : S18;
      PSE_A:  next_state = Continue ? PSE_B : PSE_A;
      PSE_B:  next_state = Continue ? PSE_B : S18;
      default: next_state = S18;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they track State cycle for cycle.
  always_comb begin
    ctrl_d = ctrl_idle();
    case (next_state)
      S18: begin
        ctrl_d.ld_mar  = 1'b1;
        ctrl_d.ld_pc   = 1'b1;
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.pcmux   = PCMUX_PC1;
      end
      S33, S25: begin
        ctrl_d.mem_oe = 1'b0;
        ctrl_d.ld_mdr = timer_done_next;
      end
      S35: begin
        ctrl_d.ld_ir    = 1'b1;
        ctrl_d.gate_mdr = 1'b1;
      end
      S32: ctrl_d.ld_ben = 1'b1;
      S01, S05, S09: begin
        ctrl_d.sr1mux   = 1'b1;
        ctrl_d.sr2mux   = IR_5;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.ld_cc    = 1'b1;
        ctrl_d.aluk     = (next_state == S01) ? ALUK_ADD :
                          (next_state == S05) ? ALUK_AND : ALUK_NOT;
      end
      S14: begin
        ctrl_d.addr2mux    = ADDR2_OFF9;
        ctrl_d.gate_marmux = 1'b1;
        ctrl_d.ld_reg      = 1'b1;
        ctrl_d.ld_cc       = 1'b1;
      end
      S06, S07: begin
        ctrl_d.sr1mux      = 1'b1;
        ctrl_d.addr1mux    = 1'b1;
        ctrl_d.addr2mux    = ADDR2_OFF6;
        ctrl_d.gate_marmux = 1'b1;
        ctrl_d.ld_mar      = 1'b1;
      end
      S27: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.ld_cc    = 1'b1;
      end
      S23: begin
        ctrl_d.aluk     = ALUK_PASS;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_mdr   = 1'b1;
      end
      S16: ctrl_d.mem_we = 1'b0;
      S04: begin
        ctrl_d.drmux   = 1'b1;
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.ld_reg  = 1'b1;
      end
      S21: begin
        ctrl_d.ld_pc = 1'b1;
        ctrl_d.pcmux = PCMUX_ADDER;
        if (IR_11) begin
          ctrl_d.addr2mux = ADDR2_OFF11;
        end else begin
          ctrl_d.sr1mux   = 1'b1;
          ctrl_d.addr1mux = 1'b1;
          ctrl_d.addr2mux = ADDR2_ZERO;
        end
      end
      S12: begin
        ctrl_d.ld_pc    = 1'b1;
        ctrl_d.pcmux    = PCMUX_ADDER;
        ctrl_d.sr1mux   = 1'b1;
        ctrl_d.addr1mux = 1'b1;
        ctrl_d.addr2mux = ADDR2_ZERO;
      end
      S22: begin
        ctrl_d.ld_pc    = 1'b1;
        ctrl_d.pcmux    = PCMUX_ADDER;
        ctrl_d.addr2mux = ADDR2_OFF9;
      end
      PSE_A: ctrl_d.ld_led = (state != PSE_A);
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= HALTED;
      ctrl_q <= ctrl_idle();
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_d;
    end
  end

  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign LD_BEN     = ctrl_q.ld_ben;
  assign LD_CC      = ctrl_q.ld_cc;
  assign LD_REG     = ctrl_q.ld_reg;
  assign LD_PC      = ctrl_q.ld_pc;
  assign LD_LED     = ctrl_q.ld_led;
  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateALU    = ctrl_q.gate_alu;
  assign GateMARMUX = ctrl_q.gate_marmux;
  assign PCMUX      = ctrl_q.pcmux;
  assign DRMUX      = ctrl_q.drmux;
  assign SR1MUX     = ctrl_q.sr1mux;
  assign SR2MUX     = ctrl_q.sr2mux;
  assign ADDR1MUX   = ctrl_q.addr1mux;
  assign ADDR2MUX   = ctrl_q.addr2mux;
  assign ALUK       = ctrl_q.aluk;
  assign Mem_CE     = 1'b0;
  assign Mem_UB     = 1'b0;
  assign Mem_LB     = 1'b0;
  assign Mem_OE     = ctrl_q.mem_oe;
  assign Mem_WE     = ctrl_q.mem_we;

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Bench for lc3_ctrl_seq: two instances (MEM_WAIT 2 and 4) checked against a per-instruction cycle model.
// Honours LC3_PAUSE_IR_EN the same way as the design.
module tb_lc3_ctrl_seq;

  typedef logic [26:0] ov_t;

  localparam ov_t B_LD_MAR = 27'h1 << 26;
  localparam ov_t B_LD_MDR = 27'h1 << 25;
  localparam ov_t B_LD_IR  = 27'h1 << 24;
  localparam ov_t B_LD_BEN = 27'h1 << 23;
  localparam ov_t B_LD_CC  = 27'h1 << 22;
  localparam ov_t B_LD_REG = 27'h1 << 21;
  localparam ov_t B_LD_PC  = 27'h1 << 20;
  localparam ov_t B_LD_LED = 27'h1 << 19;
  localparam ov_t B_G_PC   = 27'h1 << 18;
  localparam ov_t B_G_MDR  = 27'h1 << 17;
  localparam ov_t B_G_ALU  = 27'h1 << 16;
  localparam ov_t B_G_MM   = 27'h1 << 15;
  localparam ov_t B_DRMUX  = 27'h1 << 12;
  localparam ov_t B_SR1    = 27'h1 << 11;
  localparam ov_t B_SR2    = 27'h1 << 10;
  localparam ov_t B_A1     = 27'h1 << 9;
  localparam ov_t B_OE     = 27'h1 << 1;
  localparam ov_t B_WE     = 27'h1 << 0;
  localparam ov_t IDLE     = B_OE | B_WE;

  function automatic ov_t pcmux(input logic [1:0] v);  return ov_t'(v) << 13; endfunction
  function automatic ov_t addr2(input logic [1:0] v);  return ov_t'(v) << 7;  endfunction
  function automatic ov_t aluk(input logic [1:0] v);   return ov_t'(v) << 5;  endfunction

  typedef struct {
    ov_t        exp;
    logic       cont;
    logic [3:0] op;
    logic       ir5, ir11, ben;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_i  [2] = '{1'b1, 1'b1};
  logic       run_i  [2] = '{1'b0, 1'b0};
  logic       cont_i [2] = '{1'b0, 1'b0};
  logic [3:0] op_i   [2] = '{4'd0, 4'd0};
  logic       ir5_i  [2] = '{1'b0, 1'b0};
  logic       ir11_i [2] = '{1'b0, 1'b0};
  logic       ben_i  [2] = '{1'b0, 1'b0};
  wire  [26:0] ov    [2];

  step_t q[$];
  logic [3:0] m_op;
  logic m_ir5, m_ir11, m_ben;
  logic run_noise = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lc3_ctrl_seq #(.MEM_WAIT(g == 0 ? 2 : 4)) dut (
      .Clk(clk), .Reset(rst_i[g]), .Run(run_i[g]), .Continue(cont_i[g]),
      .Opcode(op_i[g]), .IR_5(ir5_i[g]), .IR_11(ir11_i[g]), .BEN(ben_i[g]),
      .LD_MAR(ov[g][26]), .LD_MDR(ov[g][25]), .LD_IR(ov[g][24]), .LD_BEN(ov[g][23]),
      .LD_CC(ov[g][22]), .LD_REG(ov[g][21]), .LD_PC(ov[g][20]), .LD_LED(ov[g][19]),
      .GatePC(ov[g][18]), .GateMDR(ov[g][17]), .GateALU(ov[g][16]), .GateMARMUX(ov[g][15]),
      .PCMUX(ov[g][14:13]), .DRMUX(ov[g][12]), .SR1MUX(ov[g][11]), .SR2MUX(ov[g][10]),
      .ADDR1MUX(ov[g][9]), .ADDR2MUX(ov[g][8:7]), .ALUK(ov[g][6:5]),
      .Mem_CE(ov[g][4]), .Mem_UB(ov[g][3]), .Mem_LB(ov[g][2]),
      .Mem_OE(ov[g][1]), .Mem_WE(ov[g][0])
    );
  end

  function automatic int unsigned mw_of(input int unsigned u);
    return (u == 0) ? 2 : 4;
  endfunction

  // ---------------- reference model: expected output vector per cycle ----------------
  function automatic void push(input ov_t e, input logic c);
    step_t s;
    s.exp = e; s.cont = c; s.op = m_op; s.ir5 = m_ir5; s.ir11 = m_ir11; s.ben = m_ben;
    q.push_back(s);
  endfunction

  // Two-level Continue handshake: k1+1 cycles waiting for high, k2+1 cycles waiting for low.
  function automatic void model_wait(input int unsigned k1, input int unsigned k2, input ov_t first);
    for (int unsigned i = 0; i <= k1; i++) push((i == 0) ? first : IDLE, i == k1);
    for (int unsigned j = 0; j <= k2; j++) push(IDLE, j != k2);
  endfunction

  function automatic void model_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                                      input logic ben, input int unsigned mw);
    ov_t alu;
    m_op = op; m_ir5 = ir5; m_ir11 = ir11; m_ben = ben;
    push(IDLE | B_LD_MAR | B_LD_PC | B_G_PC, 1'b0);
    for (int unsigned i = 0; i < mw; i++) push((IDLE & ~B_OE) | ((i == mw - 1) ? B_LD_MDR : '0), 1'b0);
    push(IDLE | B_LD_IR | B_G_MDR, 1'b0);
`ifdef LC3_PAUSE_IR_EN
    model_wait($urandom_range(0, 2), $urandom_range(0, 2), IDLE);
`else
    push(IDLE | B_LD_BEN, 1'b0);
    alu = IDLE | B_SR1 | (ir5 ? B_SR2 : '0) | B_G_ALU | B_LD_REG | B_LD_CC;
    case (op)
      4'b0001: push(alu | aluk(2'b00), 1'b0);
      4'b0101: push(alu | aluk(2'b01), 1'b0);
      4'b1001: push(alu | aluk(2'b10), 1'b0);
      4'b1110: push(IDLE | addr2(2'b10) | B_G_MM | B_LD_REG | B_LD_CC, 1'b0);
      4'b0110: begin
        push(IDLE | B_SR1 | B_A1 | addr2(2'b01) | B_G_MM | B_LD_MAR, 1'b0);
        for (int unsigned i = 0; i < mw; i++) push((IDLE & ~B_OE) | ((i == mw - 1) ? B_LD_MDR : '0), 1'b0);
        push(IDLE | B_G_MDR | B_LD_REG | B_LD_CC, 1'b0);
      end
      4'b0111: begin
        push(IDLE | B_SR1 | B_A1 | addr2(2'b01) | B_G_MM | B_LD_MAR, 1'b0);
        push(IDLE | aluk(2'b11) | B_G_ALU | B_LD_MDR, 1'b0);
        for (int unsigned i = 0; i < mw; i++) push(IDLE & ~B_WE, 1'b0);
      end
      4'b0100: begin
        push(IDLE | B_DRMUX | B_G_PC | B_LD_REG, 1'b0);
        push(IDLE | B_LD_PC | pcmux(2'b10) | (ir11 ? addr2(2'b11) : (B_A1 | B_SR1)), 1'b0);
      end
      4'b1100: push(IDLE | B_A1 | B_SR1 | pcmux(2'b10) | B_LD_PC, 1'b0);
      4'b0000: begin
        push(IDLE, 1'b0);
        if (ben) push(IDLE | addr2(2'b10) | pcmux(2'b10) | B_LD_PC, 1'b0);
      end
      4'b1101: model_wait($urandom_range(0, 3), 5, IDLE | B_LD_LED);
      default: ;
    endcase
`endif
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset(input int unsigned u);
    rst_i[u] = 1'b1; run_i[u] = 1'b0; cont_i[u] = 1'b0;
    repeat (2) @(negedge clk);
    rst_i[u] = 1'b0;
  endtask

  task automatic start(input int unsigned u);
    @(negedge clk);
    run_i[u] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int unsigned u = 0; u < 2; u++) begin
      op_i[u] = 4'($urandom); rst_i[u] = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ov[u] !== IDLE) begin
        errors++; $display("FAIL reset[%0d] got %h expected %h", u, ov[u], IDLE);
      end
      rst_i[u] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (ov[u] !== IDLE) begin
          errors++; $display("FAIL halted_hold[%0d] cyc %0d got %h expected %h", u, k, ov[u], IDLE);
        end
      end
    end
  endtask

  task automatic test_fetch_alu();
    do_reset(0); q.delete();
    model_instr(4'b0001, 1'b1, 1'b0, 1'b0, 2);
    model_instr(4'b0101, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b1001, 1'b1, 1'b0, 1'b0, 2);
    model_instr(4'b1110, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b0010, 1'b0, 1'b0, 1'b0, 2);
    start(0);
    foreach (q[i]) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== q[i].exp) begin
        errors++; $display("FAIL fetch_alu step %0d got %h expected %h", i, ov[0], q[i].exp);
      end
      run_i[0] = 1'b0; cont_i[0] = q[i].cont; op_i[0] = q[i].op;
      ir5_i[0] = q[i].ir5; ir11_i[0] = q[i].ir11; ben_i[0] = q[i].ben;
    end
  endtask

  task automatic test_str_mw4();
    do_reset(1); q.delete();
    model_instr(4'b0111, 1'b0, 1'b0, 1'b0, 4);
    model_instr(4'b0110, 1'b0, 1'b0, 1'b0, 4);
    start(1);
    foreach (q[i]) begin
      @(negedge clk);
      checks++;
      if (ov[1] !== q[i].exp) begin
        errors++; $display("FAIL str_ldr_mw4 step %0d got %h expected %h", i, ov[1], q[i].exp);
      end
      run_i[1] = 1'b0; cont_i[1] = q[i].cont; op_i[1] = q[i].op;
      ir5_i[1] = q[i].ir5; ir11_i[1] = q[i].ir11; ben_i[1] = q[i].ben;
    end
  endtask

  task automatic test_branch_jump();
    do_reset(0); q.delete();
    model_instr(4'b0000, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b0000, 1'b0, 1'b0, 1'b1, 2);
    model_instr(4'b0100, 1'b0, 1'b1, 1'b0, 2);
    model_instr(4'b0100, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b1100, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b0110, 1'b0, 1'b0, 1'b0, 2);
    start(0);
    foreach (q[i]) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== q[i].exp) begin
        errors++; $display("FAIL branch_jump step %0d got %h expected %h", i, ov[0], q[i].exp);
      end
      run_i[0] = 1'b0; cont_i[0] = q[i].cont; op_i[0] = q[i].op;
      ir5_i[0] = q[i].ir5; ir11_i[0] = q[i].ir11; ben_i[0] = q[i].ben;
    end
  endtask

  task automatic test_pause();
    do_reset(0); q.delete();
    model_instr(4'b1101, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b1101, 1'b0, 1'b0, 1'b0, 2);
    model_instr(4'b0001, 1'b0, 1'b0, 1'b0, 2);
    start(0);
    foreach (q[i]) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== q[i].exp) begin
        errors++; $display("FAIL pause step %0d got %h expected %h", i, ov[0], q[i].exp);
      end
      run_i[0] = 1'b0; cont_i[0] = q[i].cont; op_i[0] = q[i].op;
      ir5_i[0] = q[i].ir5; ir11_i[0] = q[i].ir11; ben_i[0] = q[i].ben;
    end
  endtask

  task automatic test_reset_mid_access();
    int unsigned cut;
`ifdef LC3_PAUSE_IR_EN
    cut = 1;
`else
    cut = mw_of(0) + 4;
`endif
    do_reset(0); q.delete();
    model_instr(4'b0110, 1'b0, 1'b0, 1'b0, 2);
    start(0);
    for (int unsigned i = 0; i <= cut; i++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== q[i].exp) begin
        errors++; $display("FAIL mid_reset_pre step %0d got %h expected %h", i, ov[0], q[i].exp);
      end
      run_i[0] = 1'b0; cont_i[0] = q[i].cont; op_i[0] = q[i].op;
    end
    rst_i[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ov[0] !== IDLE) begin
      errors++; $display("FAIL mid_reset_release got %h expected %h", ov[0], IDLE);
    end
    rst_i[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== IDLE) begin
        errors++; $display("FAIL mid_reset_halted cyc %0d got %h expected %h", k, ov[0], IDLE);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned u = 0; u < 2; u++) begin
      do_reset(u); q.delete();
      for (int n = 0; n < 14; n++)
        model_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), mw_of(u));
      start(u);
      run_noise = 1'b1;
      foreach (q[i]) begin
        @(negedge clk);
        checks++;
        if (ov[u] !== q[i].exp) begin
          errors++; $display("FAIL back_to_back[%0d] step %0d op %b got %h expected %h",
                             u, i, q[i].op, ov[u], q[i].exp);
        end
        run_i[u] = run_noise ? 1'($urandom) : 1'b0;
        cont_i[u] = q[i].cont; op_i[u] = q[i].op;
        ir5_i[u] = q[i].ir5; ir11_i[u] = q[i].ir11; ben_i[u] = q[i].ben;
      end
      run_noise = 1'b0;
      run_i[u]  = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch_alu();
    test_str_mw4();
    test_branch_jump();
    test_pause();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
